mdu_ctrl: RTL and testbench

//  RV32M execute-stage sequencer; sits between the ID/EX pipeline register and the

---
 rtl/mdu_ctrl.sv | 130 +++++++++++++
 tb/tb_mdu_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: RV32M execute sequencer driving an external multiplier and running a restoring divider.
module mdu_ctrl #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_func3_i,
  input  logic [XLEN-1:0] req_op1_i,
  input  logic [XLEN-1:0] req_op2_i,
  input  logic [RD_W-1:0] req_rd_i,
  output logic [XLEN-1:0] mul_op1_o,
  output logic [XLEN-1:0] mul_op2_o,
  output logic [2:0]      mul_func3_o,
  output logic            mul_en_o,
  input  logic [XLEN-1:0] mul_lo_i,
  input  logic [XLEN-1:0] mul_hi_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_data_o,
  output logic [RD_W-1:0] res_rd_o,
  output logic            busy_o
);
  typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] func3_q, func3_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, res_q, res_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [4:0] cnt_q, cnt_d;
  logic spec_q, spec_d;
  logic accept, in_sgn, sgn, ge, div0, ovf;
  logic [XLEN:0] diff;
  logic [XLEN-1:0] quo_fix, rem_fix;
  always_comb begin
    state_d = state_q;
    func3_d = func3_q;
    op1_d = op1_q;
    op2_d = op2_q;
    rd_d = rd_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvsr_d = dvsr_q;
    res_d = res_q;
    cnt_d = cnt_q;
    spec_d = spec_q;
    accept = req_valid_i & (state_q == IDLE) & !flush_i;
    in_sgn = !req_func3_i[0];
    div0 = req_op2_i == '0;
    ovf = in_sgn & (req_op1_i == 32'h8000_0000) & (req_op2_i == 32'hFFFF_FFFF);
    sgn = !func3_q[0];
    diff = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
    // a set remainder MSB means the shifted value already exceeds any 32-bit divisor
    ge = rem_q[XLEN-1] | !diff[XLEN];
    quo_fix = spec_q ? (op2_q == '0 ? '1 : 32'h8000_0000)
                     : (sgn & (op1_q[XLEN-1] ^ op2_q[XLEN-1]) ? -quo_q : quo_q);
    rem_fix = spec_q ? (op2_q == '0 ? op1_q : '0) : (sgn & op1_q[XLEN-1] ? -rem_q : rem_q);
    case (state_q)
      IDLE: if (accept) begin
        func3_d = req_func3_i;
        op1_d = req_op1_i;
        op2_d = req_op2_i;
        rd_d = req_rd_i;
        cnt_d = '0;
        rem_d = '0;
        quo_d = in_sgn & req_op1_i[XLEN-1] ? -req_op1_i : req_op1_i;
        dvsr_d = in_sgn & req_op2_i[XLEN-1] ? -req_op2_i : req_op2_i;
        spec_d = div0 | ovf;
        state_d = !req_func3_i[2] ? MUL_WAIT : (div0 | ovf) ? DIV_FIX : DIV_RUN;
      end
      MUL_WAIT: begin
        res_d = func3_q[1:0] == 2'b00 ? mul_lo_i : mul_hi_i;
        state_d = DONE;
      end
      DIV_RUN: begin
        rem_d = ge ? diff[XLEN-1:0] : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_d = {quo_q[XLEN-2:0], ge};
        cnt_d = cnt_q + 5'd1;
        state_d = cnt_q == 5'd31 ? DIV_FIX : DIV_RUN;
      end
      // first cycle applies signs/special values, second hands the result to DONE
      DIV_FIX: begin
        res_d = cnt_q == 5'd0 ? (func3_q[1] ? rem_fix : quo_fix) : res_q;
        cnt_d = 5'd1;
        state_d = cnt_q == 5'd0 ? DIV_FIX : DONE;
      end
      DONE: state_d = res_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      func3_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      rd_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvsr_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      spec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      func3_q <= func3_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      rd_q <= rd_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvsr_q <= dvsr_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      spec_q <= spec_d;
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign mul_en_o = state_q == MUL_WAIT;
  assign mul_op1_o = mul_en_o ? op1_q : '0;
  assign mul_op2_o = mul_en_o ? op2_q : '0;
  assign mul_func3_o = mul_en_o ? func3_q : '0;
  assign res_valid_o = state_q == DONE;
  assign res_data_o = res_valid_o ? res_q : '0;
  assign res_rd_o = res_valid_o ? rd_q : '0;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl with a behavioural multiplier and reference M-extension model.
module tb_mdu_ctrl;
  logic clk = 0, rst = 1, flush_i = 0, req_valid_i = 0, res_ready_i = 0;
  logic req_ready_o, mul_en_o, res_valid_o, busy_o;
  logic [2:0] req_func3_i = 0, mul_func3_o;
  logic [31:0] req_op1_i = 0, req_op2_i = 0, mul_op1_o, mul_op2_o, mul_lo_i, mul_hi_i, res_data_o;
  logic [4:0] req_rd_i = 0, res_rd_o;
  typedef struct packed {logic [31:0] d; logic [4:0] rd; logic [7:0] lat;} exp_t;
  exp_t sb_q[$];
  int n_cmp = 0, n_err = 0;

  mdu_ctrl dut (.clk(clk), .rst(rst), .flush_i(flush_i), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .req_func3_i(req_func3_i), .req_op1_i(req_op1_i),
    .req_op2_i(req_op2_i), .req_rd_i(req_rd_i), .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
    .mul_func3_o(mul_func3_o), .mul_en_o(mul_en_o), .mul_lo_i(mul_lo_i), .mul_hi_i(mul_hi_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_rd_o(res_rd_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f[1:0])
      2'b01: return sa * sb;
      2'b10: return sa * ub;
      default: return ua * ub;
    endcase
  endfunction

  assign {mul_hi_i, mul_lo_i} = prod(mul_func3_o, mul_op1_o, mul_op2_o);

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (!f[2]) begin
      p = prod(f, a, b);
      return f[1:0] == 2'b00 ? p[31:0] : p[63:32];
    end
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
    if (f[0]) return f[1] ? a % b : a / b;
    r = f[1] ? sa % sb : sa / sb;
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {31'b0, req_ready_o}, 1);
    chk({tag, "_busy"}, {31'b0, busy_o}, 0);
    chk({tag, "_valid"}, {31'b0, res_valid_o}, 0);
    chk({tag, "_mul_en"}, {31'b0, mul_en_o}, 0);
    chk({tag, "_mul_ops"}, mul_op1_o | mul_op2_o | {29'b0, mul_func3_o}, 0);
    chk({tag, "_res"}, res_data_o | {27'b0, res_rd_o}, 0);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
    exp_t e;
    int n;
    logic spec;
    spec = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    sb_q.push_back('{d: model(f, a, b), rd: rd, lat: !f[2] ? 8'd1 : spec ? 8'd2 : 8'd34});
    chk("req_ready", {31'b0, req_ready_o}, 1);
    req_func3_i = f; req_op1_i = a; req_op2_i = b; req_rd_i = rd; req_valid_i = 1;
    tick();
    req_valid_i = 0; req_op1_i = $urandom; req_op2_i = $urandom;
    chk("mul_en", {31'b0, mul_en_o}, {31'b0, !f[2]});
    if (!f[2]) chk("mul_ops", mul_op1_o ^ mul_op2_o ^ {29'b0, mul_func3_o}, a ^ b ^ {29'b0, f});
    n = 0;
    while (!res_valid_o && n < 60) begin
      tick();
      n++;
    end
    e = sb_q.pop_front();
    chk("latency", n, {24'b0, e.lat});
    chk("res_data", res_data_o, e.d);
    chk("res_rd", {27'b0, res_rd_o}, {27'b0, e.rd});
    chk("mul_en_off", {31'b0, mul_en_o}, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_data", res_data_o, e.d);
      chk("hold_rd", {27'b0, res_rd_o}, {27'b0, e.rd});
      chk("hold_ready", {30'b0, req_ready_o, res_valid_o}, 1);
    end
    res_ready_i = 1;
    tick();
    res_ready_i = 0;
    chk("back_idle", {30'b0, busy_o, res_valid_o}, 0);
  endtask

  initial begin
    int seen;
    logic [2:0] f;
    logic [31:0] a, b;
    tick(); tick();
    rst = 0;
    chk_reset("reset");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    run_op(3'b000, 32'd7, 32'd6, 5'd3, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd4, 0);
    run_op(3'b100, -32'sd7, 32'd2, 5'd5, 0);
    run_op(3'b110, -32'sd7, 32'd2, 5'd6, 0);
    run_op(3'b101, 32'd100, 32'd7, 5'd7, 0);
    run_op(3'b111, 32'd100, 32'd7, 5'd8, 0);
    run_op(3'b101, 32'h1234, 32'd0, 5'd9, 0);
    run_op(3'b111, 32'h1234, 32'd0, 5'd10, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    run_op(3'b100, 32'h8000_0000, 32'd3, 5'd13, 5);
    run_op(3'b110, 32'h7FFF_FFFF, -32'sd5, 5'd14, 0);
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_op(f, a, b, 5'(i + 16), 0);
    end
    req_func3_i = 3'b101; req_op1_i = 32'd1000; req_op2_i = 32'd9; req_rd_i = 5'd20; req_valid_i = 1;
    tick();
    req_valid_i = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("flush_busy", {31'b0, busy_o}, 1);
    flush_i = 1;
    tick();
    flush_i = 0;
    chk("flush_idle", {30'b0, busy_o, req_ready_o}, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid_o) seen++;
      tick();
    end
    chk("flush_novalid", seen, 0);
    run_op(3'b101, 32'd1000, 32'd9, 5'd21, 0);
    req_func3_i = 3'b000; req_op1_i = 32'd5; req_op2_i = 32'd5; req_rd_i = 5'd22; req_valid_i = 1;
    tick();
    req_valid_i = 0;
    chk("rst_pre_mul_en", {31'b0, mul_en_o}, 1);
    rst = 1;
    tick();
    rst = 0;
    chk_reset("midrst");
    run_op(3'b011, 32'h8000_0001, 32'h0000_0003, 5'd23, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
